// File: rtl/izh_tdm_scheduler.sv
// Time-division-multiplexed scheduler for Izhikevich neurons.
// One external update datapath is shared by N_NEURONS virtual neurons. Each
// tick starts a timestep: every neuron is issued to the datapath in turn, and
// its result is written back into the local v/u state. Spiking neurons push
// {id, step} events into a small FIFO.
//
// Ports:
//   clk, rst                  clock; synchronous active-low reset
//   tick                      one-cycle pulse starting a timestep
//   cur_in                    per-neuron input current (slice k = neuron k)
//   busy                      timestep in progress
//   dp_valid, dp_v/u/i        issue strobe and operands (zero when idle)
//   dp_v_next/u_next, dp_spike  datapath results, taken DP_LAT cycles after issue
//   ev_valid/ready/id/step    spike event stream (FIFO head)
//   step_cnt                  completed-timestep counter (mod 256)
//   ovf, tick_miss            sticky error flags
module izh_tdm_scheduler #(
  parameter int unsigned N_NEURONS  = 4,
  parameter int unsigned WIDTH      = 20,
  parameter int unsigned DP_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [WIDTH-1:0] V_RESET = 20'hF599A,
  parameter logic [WIDTH-1:0] U_RESET = 20'h0051E,
  localparam int unsigned IdW  = $clog2(N_NEURONS),
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic [N_NEURONS*WIDTH-1:0] cur_in,
  output logic                       busy,
  output logic                       dp_valid,
  output logic [WIDTH-1:0]           dp_v,
  output logic [WIDTH-1:0]           dp_u,
  output logic [WIDTH-1:0]           dp_i,
  input  logic [WIDTH-1:0]           dp_v_next,
  input  logic [WIDTH-1:0]           dp_u_next,
  input  logic                       dp_spike,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [IdW-1:0]             ev_id,
  output logic [7:0]                 ev_step,
  output logic [7:0]                 step_cnt,
  output logic                       ovf,
  output logic                       tick_miss
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StWb, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  k_q, k_d;
  logic [2:0]      wait_q, wait_d;
  logic [7:0]      step_q, step_d;
  logic            tick_miss_q, tick_miss_d;
  logic            ovf_q;

  logic [WIDTH-1:0] v_q [N_NEURONS];
  logic [WIDTH-1:0] u_q [N_NEURONS];

  logic [IdW+7:0]  fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q;
  logic            full, push_req, push, pop, drop;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    wait_d      = wait_q;
    step_d      = step_q;
    // Any tick outside IDLE (DONE included) is lost.
    tick_miss_d = tick_miss_q | (tick && (state_q != StIdle));
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          k_d     = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        wait_d  = '0;
        state_d = (DP_LAT == 1) ? StWb : StWait;
      end
      StWait: begin
        // Issue cycle plus DP_LAT-1 wait cycles lands WB on the result cycle.
        if (wait_q == 3'(DP_LAT - 2)) state_d = StWb;
        else                          wait_d  = wait_q + 3'd1;
      end
      StWb: begin
        if (k_q == IdW'(N_NEURONS - 1)) begin
          state_d = StDone;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = StIssue;
        end
      end
      StDone: begin
        step_d  = step_q + 8'd1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      k_q         <= '0;
      wait_q      <= '0;
      step_q      <= '0;
      tick_miss_q <= 1'b0;
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        v_q[i] <= V_RESET;
        u_q[i] <= U_RESET;
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      wait_q      <= wait_d;
      step_q      <= step_d;
      tick_miss_q <= tick_miss_d;
      if (state_q == StWb) begin
        v_q[k_q] <= dp_v_next;
        u_q[k_q] <= dp_u_next;
      end
    end
  end

  // Event FIFO. A pop needs a non-empty FIFO, so push-to-empty never bypasses.
  assign push_req = (state_q == StWb) && dp_spike;
  assign pop      = (count_q != '0) && ev_ready;
  assign full     = (count_q == (PtrW+1)'(FIFO_DEPTH));
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= {k_q, step_q};
  end

  assign busy      = (state_q != StIdle);
  assign dp_valid  = (state_q == StIssue);
  assign dp_v      = dp_valid ? v_q[k_q] : '0;
  assign dp_u      = dp_valid ? u_q[k_q] : '0;
  assign dp_i      = dp_valid ? cur_in[int'(k_q)*WIDTH +: WIDTH] : '0;
  assign ev_valid  = (count_q != '0);
  assign {ev_id, ev_step} = fifo_q[rptr_q];
  assign step_cnt  = step_q;
  assign ovf       = ovf_q;
  assign tick_miss = tick_miss_q;

endmodule

// File: tb/tb_izh_tdm_scheduler.sv
module tb_izh_tdm_scheduler;

  localparam int W = 20;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst, tick, ev_ready, dp_spike;
  logic [N*W-1:0] cur_in;
  logic           busy, dp_valid, ev_valid, ovf, tick_miss;
  logic [W-1:0]   dp_v, dp_u, dp_i, dp_v_next, dp_u_next;
  logic [1:0]     ev_id;
  logic [7:0]     ev_step, step_cnt;

  int checks = 0;
  int errors = 0;
  int lat;
  int n_iss;
  int         iss_cyc [8];
  logic [W-1:0] iss_v [8];
  logic [W-1:0] iss_u [8];
  logic [W-1:0] iss_i [8];

  always #5 clk = ~clk;

  izh_tdm_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .cur_in(cur_in), .busy(busy),
    .dp_valid(dp_valid), .dp_v(dp_v), .dp_u(dp_u), .dp_i(dp_i),
    .dp_v_next(dp_v_next), .dp_u_next(dp_u_next), .dp_spike(dp_spike),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_id(ev_id), .ev_step(ev_step),
    .step_cnt(step_cnt), .ovf(ovf), .tick_miss(tick_miss)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slice k = 0x1000*(k+1); bit 0 tells the datapath model to spike.
  task automatic set_cur(input logic [3:0] mask);
    for (int k = 0; k < N; k++) cur_in[k*W +: W] = W'(32'h1000 * (k + 1)) | W'(mask[k]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b0;
    tick = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b1;
    tick = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  // One timestep; also acts as the datapath (v+1, u+1, spike = dp_i[0]).
  // Cycle n is the n-th cycle after the edge that samples tick.
  task automatic run_step(input int miss_at, input int abort_at, output int latency);
    n_iss   = 0;
    latency = -1;
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      tick = (n == miss_at);
      rst  = (n != abort_at);
      if (dp_valid) begin
        if (n_iss < 8) begin
          iss_cyc[n_iss] = n;
          iss_v[n_iss]   = dp_v;
          iss_u[n_iss]   = dp_u;
          iss_i[n_iss]   = dp_i;
        end
        n_iss++;
        dp_v_next = dp_v + 20'd1;
        dp_u_next = dp_u + 20'd1;
        dp_spike  = dp_i[0];
      end
      if (!busy) begin
        latency = n;
        break;
      end
    end
    tick = 1'b0;
    rst  = 1'b1;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; ev_ready = 1'b0; dp_spike = 1'b0;
    dp_v_next = '0; dp_u_next = '0;
    set_cur(4'b0000);

    // Reset with tick held high: tick must be ignored.
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_dp_valid", dp_valid, 0);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_step_cnt", step_cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_tick_miss", tick_miss, 0);
    chk("idle_dp_i_zero", dp_i, 0);
    chk("idle_dp_v_zero", dp_v, 0);

    // Single timestep, no spikes.
    run_step(0, 0, lat);
    chk("latency", lat, 14);
    chk("n_issue", n_iss, 4);
    chk("issue_cyc0", iss_cyc[0], 1);
    chk("issue_cyc1", iss_cyc[1], 4);
    chk("issue_cyc2", iss_cyc[2], 7);
    chk("issue_cyc3", iss_cyc[3], 10);
    chk("issue_v0", iss_v[0], 32'hF599A);
    chk("issue_u3", iss_u[3], 32'h0051E);
    chk("issue_i2", iss_i[2], 32'h03000);
    chk("step1_cnt", step_cnt, 1);
    chk("step1_ev_valid", ev_valid, 0);
    chk("step1_tick_miss", tick_miss, 0);

    // Second timestep sees written-back state; extra tick at cycle 5.
    run_step(5, 0, lat);
    chk("wb_v0", iss_v[0], 32'hF599B);
    chk("wb_v3", iss_v[3], 32'hF599B);
    chk("wb_u1", iss_u[1], 32'h0051F);
    chk("miss_flag", tick_miss, 1);
    repeat (20) @(negedge clk);
    chk("miss_step_cnt", step_cnt, 2);
    chk("miss_busy", busy, 0);

    // Spikes on neurons 1 and 3.
    do_reset();
    chk("rst2_tick_miss", tick_miss, 0);
    chk("rst2_step_cnt", step_cnt, 0);
    set_cur(4'b1010);
    run_step(0, 0, lat);
    chk("ev_valid", ev_valid, 1);
    chk("ev_id_a", ev_id, 1);
    chk("ev_step_a", ev_step, 0);
    chk("ev_ovf", ovf, 0);
    pop_one();
    chk("ev_id_b", ev_id, 3);
    chk("ev_step_b", ev_step, 0);
    pop_one();
    chk("ev_empty", ev_valid, 0);

    // All neurons spike two steps: FIFO fills, second batch dropped.
    set_cur(4'b1111);
    run_step(0, 0, lat);
    chk("full_ovf0", ovf, 0);
    run_step(0, 0, lat);
    chk("full_ovf1", ovf, 1);
    for (int k = 0; k < N; k++) begin
      chk("fifo_ev_valid", ev_valid, 1);
      chk("fifo_id", ev_id, k);
      chk("fifo_step", ev_step, 1);
      pop_one();
    end
    chk("fifo_drained", ev_valid, 0);
    chk("ovf_sticky", ovf, 1);

    // Reset during WAIT of neuron 2.
    do_reset();
    set_cur(4'b1111);
    run_step(0, 8, lat);
    chk("abort_busy", busy, 0);
    chk("abort_ev_valid", ev_valid, 0);
    chk("abort_step_cnt", step_cnt, 0);
    chk("abort_ovf", ovf, 0);
    set_cur(4'b0000);
    run_step(0, 0, lat);
    chk("abort_restart_i0", iss_i[0], 32'h01000);
    chk("abort_restart_v0", iss_v[0], 32'hF599A);
    chk("abort_latency", lat, 14);
    chk("abort_step1", step_cnt, 1);

    // Step counter wrap.
    for (int s = 0; s < 255; s++) run_step(0, 0, lat);
    chk("wrap_step_cnt", step_cnt, 0);
    set_cur(4'b0100);
    run_step(0, 0, lat);
    chk("wrap_ev_id", ev_id, 2);
    chk("wrap_ev_step", ev_step, 0);
    chk("wrap_step_after", step_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/izh_tdm_scheduler.md
IZH_TDM_SCHEDULER -- requirements
Module: izh_tdm_scheduler

Interface
REQ-001 SHALL have parameter N_NEURONS, default 4, the number of virtual neurons sharing one update datapath (power of 2, 2..16).
REQ-002 SHALL have parameter WIDTH, default 20, the signed fixed-point word width (4 integer, 16 fraction bits).
REQ-003 SHALL have parameter DP_LAT, default 2, the datapath latency in cycles from dp_valid to result-valid (1..8).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, the spike-event FIFO depth (power of 2).
REQ-005 SHALL have parameters V_RESET, default 20'hF599A (-0.65), and U_RESET, default 20'h0051E (0.02), the power-up membrane and recovery values.
REQ-006 Ports SHALL be (name direction width meaning):
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- tick  in  1  one-cycle pulse starting a timestep
- cur_in  in  N_NEURONS*WIDTH  per-neuron input current; slice k is neuron k
- busy  out  1  timestep in progress
- dp_valid  out  1  one-cycle issue strobe to datapath
- dp_v, dp_u, dp_i  out  WIDTH each  operands for current neuron
- dp_v_next, dp_u_next  in  WIDTH each  datapath results
- dp_spike  in  1  datapath spike flag
- ev_valid  out  1  spike event available
- ev_ready  in  1  consumer accepts event
- ev_id  out  log2(N_NEURONS)  spiking neuron index
- ev_step  out  8  timestep number of event
- step_cnt  out  8  completed-timestep counter
- ovf  out  1  sticky: event dropped, FIFO full
- tick_miss  out  1  sticky: tick received while busy

Function
REQ-007 SHALL hold per-neuron v[k], u[k] in internal WIDTH-bit signed registers; the datapath SHALL hold no neuron state.
REQ-008 FSM states SHALL be IDLE, ISSUE, WAIT, WB, DONE.
REQ-009 IDLE: on tick=1, SHALL set k=0, go to ISSUE; busy=1 from the next cycle until return to IDLE.
REQ-010 ISSUE: SHALL assert dp_valid=1 for exactly one cycle with dp_v=v[k], dp_u=u[k], dp_i=cur_in slice k (sampled that cycle); then WAIT.
REQ-011 WAIT: SHALL count DP_LAT-1 cycles, then WB; DP_LAT=1 goes directly to WB.
REQ-012 WB: SHALL write v[k]<=dp_v_next, u[k]<=dp_u_next; if dp_spike=1, SHALL push event {id=k, step=step_cnt}; if k==N_NEURONS-1 go to DONE, else k<=k+1 and ISSUE.
REQ-013 DONE: SHALL increment step_cnt (mod 256, wraps 255->0) and go to IDLE; busy=0 in IDLE.
REQ-014 Timestep latency SHALL be exactly N_NEURONS*(DP_LAT+1)+2 cycles from tick to busy falling (4 neurons, DP_LAT=2: 14).
REQ-015 dp_v, dp_u, dp_i SHALL be 0 when dp_valid=0.
REQ-016 tick while busy=1 SHALL be ignored and set tick_miss=1; tick in the DONE cycle counts as busy.
REQ-017 Event FIFO: ev_valid=1 iff non-empty; ev_id/ev_step show head; pop when ev_valid&&ev_ready.
REQ-018 Push when full with no simultaneous pop SHALL drop the event and set ovf=1; push and pop in the same cycle when full SHALL both succeed, count unchanged.
REQ-019 Push and pop when empty SHALL not bypass: event becomes visible next cycle.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH; order SHALL be first-in first-out.
REQ-021 Datapath results SHALL be taken without saturation or modification; sign convention is two's complement.

Reset
REQ-022 On rst=0 at a clk edge SHALL set: state IDLE, k=0, all v[k]=V_RESET, u[k]=U_RESET, FIFO empty, step_cnt=0, ovf=0, tick_miss=0, busy=0, dp_valid=0, ev_valid=0.
REQ-023 Reset mid-timestep SHALL abort immediately; no partial write-back or step_cnt increment.
REQ-024 tick sampled in the same cycle as rst=0 SHALL be ignored.

Verification
REQ-025 Reset then single tick, datapath model returns v+1, u+1, no spike -> dp_valid pulses at cycles 1,4,7,10; busy falls at cycle 14; step_cnt=1; v[k]=V_RESET+1.
REQ-026 Datapath spikes for neurons 1 and 3, ev_ready=0 -> ev_valid=1, events (1,0) then (3,0) in order, ovf=0.
REQ-027 All 4 neurons spike for 2 steps, ev_ready=0 -> 4 events held, next 4 dropped, ovf=1 stays until reset.
REQ-028 tick at cycle 5 of a timestep -> ignored, tick_miss=1, step_cnt advances by 1 only.
REQ-029 rst=0 during WAIT of neuron 2 -> all state at reset values, no event pushed, next tick restarts at neuron 0.
REQ-030 Run 256 ticks -> step_cnt wraps to 0; ev_step of next event equals 0.
